tcpip_tx_sched: RTL

Frame-launch scheduler for the UDP/IP/MAC transmit path. It watches the read-side fill level of the application TX FIFO and decides when to start a frame and how many payload bytes it carries. A frame launches when a full frame's worth of data is queued, or when a timeout expires with a partial frame queued. It allows one frame in flight, waits for completion, then enforces the Ethernet inter-frame gap before arming again. Sits between the app FIFO status and the header/packer chain (udp_pack/ip_pack/mac_pack).

---
 rtl/tcpip_pkg.sv | 17 +
 rtl/sched_timer.sv | 23 ++
 rtl/tcpip_tx_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/tcpip_pkg.sv
// Shared definitions for the UDP/IP/MAC transmit path: scheduler state encoding
// and frame geometry. The largest payload is whatever the frame RAM holds after headers.
package tcpip_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3,
    IFG       = 3'd4
  } sched_state_t;

  localparam int ETH_HDR_LEN     = 14;
  localparam int IP_HDR_LEN      = 20;
  localparam int UDP_HDR_LEN     = 8;
  localparam int FRAME_RAM_DEPTH = 1024;
  localparam int MAX_PAYLOAD     = FRAME_RAM_DEPTH - ETH_HDR_LEN - IP_HDR_LEN - UDP_HDR_LEN;
endpackage

// File: rtl/sched_timer.sv
// Clear/enable counter that saturates at TERM; tc flags the terminal count.
module sched_timer #(
  parameter int W    = 4,
  parameter int TERM = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] cnt;

  assign tc = (cnt == TERM_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/tcpip_tx_sched.sv
// TX frame-launch scheduler: launches on a full frame or on timeout with partial data,
// one frame in flight, then enforces the inter-frame gap.
// Optional statistics ports (flush_cnt, stall_cnt) under TCPIP_SCHED_STATS_EN.
module tcpip_tx_sched
  import tcpip_pkg::*;
#(
  parameter int MAX_PAYLOAD = tcpip_pkg::MAX_PAYLOAD,
  parameter int LEN_W       = 11,
  parameter int TIMEOUT_CYC = 12500,
  parameter int IFG_CYC     = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sched_en,
  input  logic [LEN_W-1:0] pay_thresh,
  input  logic [LEN_W-1:0] fifo_level,
  input  logic             tx_en,
  input  logic             frame_done,
  output logic             frame_start,
  output logic [LEN_W-1:0] frame_len,
  output logic             sched_busy,
  output logic [15:0]      frame_cnt
`ifdef TCPIP_SCHED_STATS_EN
  ,
  output logic [15:0]      flush_cnt,
  output logic [15:0]      stall_cnt
`endif
);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
  localparam logic [LEN_W-1:0] MAX_PAY_V = LEN_W'(MAX_PAYLOAD);

  sched_state_t     state, state_nxt;
  logic [LEN_W-1:0] eff_thr, len_nxt;
  logic             lvl_nz, thr_hit, tmo_tc, gap_tc;
  logic             launch, tmo_launch;

  always_comb begin
    eff_thr = pay_thresh;
    if (pay_thresh == '0)            eff_thr = LEN_W'(1);
    else if (pay_thresh > MAX_PAY_V) eff_thr = MAX_PAY_V;
  end

  assign lvl_nz  = |fifo_level;
  assign thr_hit = (fifo_level >= eff_thr);

  // Timeout only accumulates in ARM with data queued; any empty sample restarts it.
  sched_timer #(.W(TMO_W), .TERM(TIMEOUT_CYC - 1)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != ARM) || !lvl_nz),
    .en    (state == ARM),
    .tc    (tmo_tc)
  );

  // Gap needs IFG_CYC consecutive idle cycles; a tx_en blip starts it over.
  sched_timer #(.W(GAP_W), .TERM(IFG_CYC - 1)) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != IFG) || tx_en),
    .en    (state == IFG),
    .tc    (gap_tc)
  );

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    tmo_launch = 1'b0;
    len_nxt    = frame_len;
    case (state)
      IDLE:      if (sched_en) state_nxt = ARM;
      ARM: begin
        if (thr_hit) begin
          launch  = 1'b1;
          len_nxt = eff_thr;
        end else if (lvl_nz && tmo_tc) begin
          launch     = 1'b1;
          tmo_launch = 1'b1;
          len_nxt    = fifo_level;
        end else if (!sched_en) begin
          state_nxt = IDLE;
        end
        if (launch) state_nxt = LAUNCH;
      end
      LAUNCH:    state_nxt = WAIT_DONE;
      WAIT_DONE: if (frame_done) state_nxt = IFG;
      IFG:       if (!tx_en && gap_tc) state_nxt = sched_en ? ARM : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_len <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      frame_len <= len_nxt;
      frame_cnt <= frame_cnt + 16'(launch);
    end
  end

  assign frame_start = (state == LAUNCH);
  assign sched_busy  = (state == LAUNCH) || (state == WAIT_DONE) || (state == IFG);

`ifdef TCPIP_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      flush_cnt <= flush_cnt + 16'(tmo_launch);
      stall_cnt <= stall_cnt + 16'((state == ARM) && lvl_nz);
    end
  end
`endif
endmodule
